// File: rtl/delay_line_ctrl.sv
// Variable-length sample delay line with valid tracking and fill/primed status.
// Define DLINE_TAPS_EN to expose every stage on o_taps (convolution window).
module delay_line_ctrl #(
  parameter  int D  = 16,
  parameter  int N  = 27,
  localparam int LW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [LW-1:0] i_len,
  input  logic          i_valid,
  input  logic [D-1:0]  i_data,
  output logic          o_valid,
  output logic [D-1:0]  o_data,
  output logic          o_primed
`ifdef DLINE_TAPS_EN
  ,
  output logic [D*N-1:0] o_taps
`endif
);

  logic [N-1:0][D-1:0] stage;
  logic [N-1:0]        vld;
  logic [LW-1:0]       fill;
  logic [LW-1:0]       len_eff;
  logic [LW-1:0]       sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage <= '0;
      vld   <= '0;
      fill  <= '0;
    end else if (i_clr) begin
      stage <= '0;
      vld   <= '0;
      fill  <= '0;
    end else if (i_en) begin
      stage <= {stage[N-2:0], i_data};
      vld   <= {vld[N-2:0], i_valid};
      // bubbles never reduce fill; it only counts valid arrivals up to N
      if (i_valid && (fill != LW'(N))) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_comb begin
    len_eff = i_len;
    if (i_len == '0) begin
      len_eff = LW'(1);
    end else if (i_len > LW'(N)) begin
      len_eff = LW'(N);
    end
  end

  assign sel      = len_eff - 1'b1;
  assign o_data   = stage[sel];
  assign o_valid  = vld[sel];
  assign o_primed = (fill >= len_eff);

`ifdef DLINE_TAPS_EN
  assign o_taps = stage;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: queue-based reference model, directed cases, random traffic.
module tb_delay_line_ctrl;
  localparam int D  = 16;
  localparam int N  = 27;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, valid;
  logic [LW-1:0] len;
  logic [D-1:0]  data;
  logic          o_valid, o_primed;
  logic [D-1:0]  o_data;
`ifdef DLINE_TAPS_EN
  logic [D*N-1:0] o_taps;
`endif

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  delay_line_ctrl #(.D(D), .N(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_len(len),
    .i_valid(valid), .i_data(data), .o_valid(o_valid), .o_data(o_data),
    .o_primed(o_primed)
`ifdef DLINE_TAPS_EN
    , .o_taps(o_taps)
`endif
  );

  always #5 clk = ~clk;

  // Reference: newest sample at index 0; line holds at most N samples.
  typedef struct packed { logic v; logic [D-1:0] d; } samp_t;
  samp_t q[$];
  int    m_fill = 0;

  function automatic int eff_len(int l);
    if (l == 0) return 1;
    if (l > N) return N;
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_fill = 0;
    end else if (clr) begin
      q.delete();
      m_fill = 0;
    end else if (en) begin
      q.push_front({valid, data});
      if (q.size() > N) void'(q.pop_back());
      if (valid && m_fill < N) m_fill++;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      int    l;
      samp_t e;
      l = eff_len(int'(len));
      e = (l - 1 < q.size()) ? q[l-1] : '0;
      chk("model_data", 64'(o_data), 64'(e.d));
      chk("model_valid", 64'(o_valid), 64'(e.v));
      chk("model_primed", 64'(o_primed), 64'(m_fill >= l));
`ifdef DLINE_TAPS_EN
      for (int k = 0; k < N; k++)
        chk("model_tap", 64'(o_taps[k*D +: D]), (k < q.size()) ? 64'(q[k].d) : 64'd0);
`endif
    end
  end

  task automatic drive(bit e, bit c, bit v, logic [D-1:0] d, logic [LW-1:0] l);
    en = e; clr = c; valid = v; data = d; len = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic flush();
    drive(1, 1, 0, '0, len);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, '0, 5'd5);
    #3;
    chk("reset_data", 64'(o_data), 64'd0);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_primed", 64'(o_primed), 64'd0);
    #9 rst_n = 1'b1;
    cmp_on = 1'b1;

    // sample 1 emerges after exactly 5 advances at len 5
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 1, D'(i), 5'd5);
      tick();
      if (i == 4) begin
        chk("l5_valid_early", 64'(o_valid), 64'd0);
        chk("l5_primed_early", 64'(o_primed), 64'd0);
      end
    end
    chk("l5_data", 64'(o_data), 64'd1);
    chk("l5_valid", 64'(o_valid), 64'd1);
    chk("l5_primed", 64'(o_primed), 64'd1);

    // alternating enable: only enabled edges advance
    flush();
    begin
      int cnt = 0;
      for (int c = 0; c < 10; c++) begin
        if (c % 2 == 0) begin cnt++; drive(1, 0, 1, D'(cnt), 5'd5); end
        else drive(0, 0, 1, 16'hFFFF, 5'd5);
        tick();
        if (c == 7) chk("toggle_valid_early", 64'(o_valid), 64'd0);
      end
    end
    chk("toggle_data", 64'(o_data), 64'd1);
    chk("toggle_valid", 64'(o_valid), 64'd1);

    // len 0 acts as 1; len 31 clamps to N
    flush();
    drive(1, 0, 1, 16'h5A5A, 5'd0);
    tick();
    chk("len0_data", 64'(o_data), 64'h5A5A);
    flush();
    for (int i = 1; i <= N; i++) begin
      drive(1, 0, 1, D'(i), 5'd31);
      tick();
    end
    chk("len31_data", 64'(o_data), 64'd1);
    chk("len31_primed", 64'(o_primed), 64'd1);
    drive(1, 0, 1, D'(N + 1), 5'd31);
    tick();
    chk("lenN_drop", 64'(o_data), 64'd2);

    // clear beats enable and discards its sample
    flush();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 1, D'(i), 5'd5);
      tick();
    end
    drive(1, 1, 1, 16'hABCD, 5'd5);
    tick();
    chk("clr_valid", 64'(o_valid), 64'd0);
    chk("clr_primed", 64'(o_primed), 64'd0);
    for (int i = 0; i < 30; i++) begin
      drive(1, 0, 0, '0, LW'(1 + (i % N)));
      tick();
      chk("clr_no_abcd", 64'(o_data == 16'hABCD), 64'd0);
    end

    // widening len re-evaluates primed immediately
    flush();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 1, D'(i), 5'd4);
      tick();
    end
    chk("len4_primed", 64'(o_primed), 64'd1);
    len = 5'd12;
    #1;
    chk("len12_primed_drop", 64'(o_primed), 64'd0);
    for (int i = 9; i <= 12; i++) begin
      drive(1, 0, 1, D'(i), 5'd12);
      tick();
      chk("len12_primed", 64'(o_primed), 64'(i == 12));
    end
    chk("len12_data", 64'(o_data), 64'd1);

    // asynchronous reset mid-stream
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_primed", 64'(o_primed), 64'd0);
    tick();
    rst_n = 1'b1;

`ifdef DLINE_TAPS_EN
    drive(1, 0, 1, 16'h11, 5'd5); tick();
    drive(1, 0, 1, 16'h22, 5'd5); tick();
    drive(1, 0, 1, 16'h33, 5'd5); tick();
    chk("tap0", 64'(o_taps[15:0]), 64'h33);
    chk("tap1", 64'(o_taps[31:16]), 64'h22);
    chk("tap2", 64'(o_taps[47:32]), 64'h11);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 4) != 0, D'($urandom), LW'($urandom_range(0, 31)));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        len = LW'($urandom_range(0, 31));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
